// File: rtl/iob_rr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_rr_arbiter_pkg : shared FSM encoding and constants for the RR arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package iob_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int   ARB_TIMEOUT_DEF   = 1024;
  // An aborted transaction returns read data with every bit set to this value.
  localparam logic ARB_ERR_RDATA_BIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/iob_rr_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_rr_prio_enc : combinational round-robin one-hot select after 'last'
// Rev 1.0
// ---------------------------------------------------------------------------
module iob_rr_prio_enc #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt
);

  logic w_found;

  // Requesters above 'last' win first; otherwise wrap around to the lowest index.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && req[j] && (j > int'(last))) begin
        gnt[j]  = 1'b1;
        w_found = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && req[j] && (j <= int'(last))) begin
        gnt[j]  = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_rr_arbiter : round-robin arbiter, N native masters onto one native slave
// Optional slave timeout enabled by defining IOB_ARB_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module iob_rr_arbiter
  import iob_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = ARB_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(N_MASTERS - 1);

  arb_state_t             r_state, w_state_nxt;
  logic [N_MASTERS-1:0]   r_grant, w_grant_nxt, w_pe_gnt;
  logic [IDX_W-1:0]       r_last, w_last_nxt, w_g_idx;
  logic                   w_g_valid, w_done, w_to;

  iob_rr_prio_enc #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req  (m_valid),
    .last (r_last),
    .gnt  (w_pe_gnt)
  );

  always_comb begin
    w_g_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant[i]) w_g_idx = IDX_W'(i);
    end
  end

  assign w_g_valid = (r_state == ST_BUSY) && (|(m_valid & r_grant));
  assign w_done    = w_g_valid && s_ready;

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Held at zero while idle so the first BUSY cycle counts as cycle 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == ST_IDLE) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign w_to = w_g_valid && !s_ready && (r_cnt == c_cnt_last);
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if ((r_state == ST_BUSY) && r_grant[i]) begin
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign s_valid     = w_g_valid;
  assign m_ready     = (w_done || w_to) ? r_grant : '0;
  assign m_rdata     = w_to ? {DATA_W{ARB_ERR_RDATA_BIT}} : s_rdata;
  assign timeout_err = w_to;
  assign grant       = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|m_valid) begin
          w_grant_nxt = w_pe_gnt;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Abandon leaves 'last' alone so the dropped master keeps its turn.
        if (!w_g_valid) begin
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_done || w_to) begin
          w_grant_nxt = '0;
          w_last_nxt  = w_g_idx;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= c_last_rst;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iob_rr_arbiter : scoreboard bench for iob_rr_arbiter (2 masters)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_iob_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef IOB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NM-1:0]   m_valid;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [NM-1:0]   m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic [NM-1:0]   grant;
  logic            timeout_err;

  iob_rr_arbiter #(
    .N_MASTERS (NM),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [NM-1:0] grant;
    logic         sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic [SW-1:0] ss;
    logic         terr;
  } cyc_rec_t;

  typedef struct {
    int            cyc;
    logic [NM-1:0] rdy;
    logic [DW-1:0] rdata;
  } comp_t;

  cyc_rec_t cyc_q[$];
  comp_t    comp_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc_no  = 0;

  // Reference model: is a transaction in flight, whose, who was served last,
  // and how many busy cycles have elapsed.
  bit mb     = 1'b0;
  int mg     = 0;
  int ml     = NM - 1;
  int mcnt   = 0;
  int done_g = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
  endfunction

  task automatic push_exp();
    cyc_rec_t r;
    comp_t    c;
    bit       act, hit_to, fin;
    act    = mb && m_valid[mg];
    hit_to = TO_EN && (mcnt == TO - 1);
    fin    = act && (s_ready || hit_to);
    r.cyc   = cyc_no;
    r.grant = mb ? NM'(1 << mg) : '0;
    r.sv    = act;
    r.sa    = mb ? m_addr[mg*AW +: AW]  : '0;
    r.sd    = mb ? m_wdata[mg*DW +: DW] : '0;
    r.ss    = mb ? m_wstrb[mg*SW +: SW] : '0;
    r.terr  = act && !s_ready && hit_to;
    cyc_q.push_back(r);
    done_g = -1;
    if (fin) begin
      c.cyc   = cyc_no;
      c.rdy   = NM'(1 << mg);
      c.rdata = s_ready ? s_rdata : '1;
      comp_q.push_back(c);
      done_g = mg;
    end
  endtask

  task automatic model_edge();
    if (mb) begin
      if (!m_valid[mg]) mb = 1'b0;
      else if (s_ready || (TO_EN && mcnt == TO - 1)) begin
        mb = 1'b0;
        ml = mg;
      end else mcnt++;
    end else if (|m_valid) begin
      for (int k = 1; k <= NM; k++) begin
        if (m_valid[(ml + k) % NM]) begin
          mg = (ml + k) % NM;
          break;
        end
      end
      mb   = 1'b1;
      mcnt = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
  endtask

  task automatic step();
    push_exp();
    advance();
  endtask

  task automatic new_req(input int i);
    m_valid[i]          = 1'b1;
    m_addr[i*AW +: AW]  = $urandom();
    m_wdata[i*DW +: DW] = $urandom();
    m_wstrb[i*SW +: SW] = ($urandom_range(0, 1) == 1) ? SW'($urandom()) : '0;
  endtask

  task automatic rand_masters();
    for (int i = 0; i < NM; i++) begin
      if (done_g == i) begin
        m_valid[i] = 1'b0;
        if ($urandom_range(0, 99) < 40) new_req(i);
      end else if (!m_valid[i]) begin
        if ($urandom_range(0, 99) < 35) new_req(i);
      end else if ($urandom_range(0, 99) < 2) begin
        m_valid[i] = 1'b0;
      end
    end
    s_ready = ($urandom_range(0, 99) < 30);
    s_rdata = $urandom();
  endtask

  // Monitor: per-cycle expectations plus completions from the scoreboard queue.
  always @(negedge clk) begin
    cyc_rec_t r;
    comp_t    c;
    if (cyc_q.size() > 0) begin
      r = cyc_q.pop_front();
      chk("grant",       grant,       r.grant);
      chk("s_valid",     s_valid,     r.sv);
      chk("s_addr",      s_addr,      r.sa);
      chk("s_wdata",     s_wdata,     r.sd);
      chk("s_wstrb",     s_wstrb,     r.ss);
      chk("timeout_err", timeout_err, r.terr);
      if (comp_q.size() > 0 && comp_q[0].cyc == r.cyc) begin
        c = comp_q.pop_front();
        chk("m_ready", m_ready, c.rdy);
        if (m_ready === c.rdy) chk("m_rdata", m_rdata, c.rdata);
      end else if (m_ready !== '0) begin
        chk("m_ready_spurious", m_ready, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] gseq[$];
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",   grant,       '0);
    chk("rst_s_valid", s_valid,     '0);
    chk("rst_m_ready", m_ready,     '0);
    chk("rst_terr",    timeout_err, '0);
    chk("rst_s_addr",  s_addr,      '0);
    rst = 1'b0;

    // single read from master 0, slave answers two cycles after the request
    m_valid = 2'b01;
    m_addr[0 +: AW]  = 32'h100;
    m_wstrb[0 +: SW] = '0;
    step();
    step();
    s_ready = 1'b1;
    s_rdata = 32'hCAFE0001;
    #1;
    chk("rd_s_addr",  s_addr,  32'h100);
    chk("rd_m_ready", m_ready, 2'b01);
    chk("rd_m_rdata", m_rdata, 32'hCAFE0001);
    step();
    m_valid = '0;
    s_ready = 1'b0;
    step();

    // write from master 1
    m_valid = 2'b10;
    m_addr[AW +: AW]  = 32'h8;
    m_wdata[DW +: DW] = 32'h12345678;
    m_wstrb[SW +: SW] = 4'hF;
    step();
    s_ready = 1'b1;
    #1;
    chk("wr_s_wstrb", s_wstrb, 4'hF);
    chk("wr_s_wdata", s_wdata, 32'h12345678);
    chk("wr_m_ready", m_ready, 2'b10);
    step();
    m_valid = '0;
    s_ready = 1'b0;
    step();

    // contention with both requests held and the slave always ready
    m_valid = 2'b11;
    s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (grant != '0) gseq.push_back(grant);
      step();
    end
    chk("rr_count", gseq.size(), 4);
    if (gseq.size() == 4) begin
      chk("rr_g0", gseq[0], 2'b01);
      chk("rr_g1", gseq[1], 2'b10);
      chk("rr_g2", gseq[2], 2'b01);
      chk("rr_g3", gseq[3], 2'b10);
    end
    m_valid = '0;
    s_ready = 1'b0;
    step();

    // master 0 abandons; its turn must survive
    m_valid = 2'b01;
    step();
    step();
    m_valid = '0;
    #1;
    chk("ab_s_valid", s_valid, 1'b0);
    chk("ab_m_ready", m_ready, '0);
    step();
    #1;
    chk("ab_idle_grant", grant, '0);
    m_valid = 2'b11;
    step();
    chk("ab_last_kept", grant, 2'b01);
    s_ready = 1'b1;
    step();
    m_valid = '0;
    s_ready = 1'b0;
    step();

    // asynchronous reset in the middle of a transaction
    m_valid = 2'b01;
    step();
    s_ready = 1'b1;
    m_valid = 2'b11;
    rst     = 1'b1;
    #1;
    chk("rstb_s_valid", s_valid, 1'b0);
    chk("rstb_grant",   grant,   '0);
    chk("rstb_m_ready", m_ready, '0);
    mb   = 1'b0;
    ml   = NM - 1;
    mcnt = 0;
    push_exp();
    @(negedge clk);
    #1;
    rst     = 1'b0;
    s_ready = 1'b0;
    advance();
    chk("rstb_master0_first", grant, 2'b01);
    s_ready = 1'b1;
    step();
    m_valid = '0;
    s_ready = 1'b0;
    step();

`ifdef IOB_ARB_TIMEOUT_EN
    // silent slave: abort on the TO-th busy cycle
    m_valid = 2'b10;
    step();
    repeat (TO - 1) step();
    #1;
    chk("to_m_ready", m_ready,     2'b10);
    chk("to_m_rdata", m_rdata,     32'hFFFFFFFF);
    chk("to_err",     timeout_err, 1'b1);
    step();
    m_valid = '0;
    step();
    // s_ready arriving on the abort cycle completes normally
    m_valid = 2'b01;
    step();
    repeat (TO - 1) step();
    s_ready = 1'b1;
    s_rdata = 32'h5A5A0000;
    #1;
    chk("to_race_err",     timeout_err, 1'b0);
    chk("to_race_m_ready", m_ready,     2'b01);
    chk("to_race_m_rdata", m_rdata,     32'h5A5A0000);
    step();
    m_valid = '0;
    s_ready = 1'b0;
    step();
`endif

    // randomized traffic against the model
    repeat (3000) begin
      rand_masters();
      step();
    end

    m_valid = '0;
    s_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    chk("comp_q_drained", comp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
